// File: rtl/phv_queue_buffer_pkg.sv
// Shared constants for the per-queue PHV buffer: default PHV width, queue count
// and the position of the queue bitmap inside a PHV.
package phv_queue_buffer_pkg;

    localparam int PHV_LEN_DEF = 48*8 + 32*8 + 16*8 + 256;
    localparam int NUM_QUEUES  = 4;
    localparam int QBMP_POS    = 141;
    localparam int QBMP_W      = 4;

    // Extracts the output-queue bitmap the last stage writes into the PHV.
    function automatic logic [QBMP_W-1:0] phv_qbmp(input logic [PHV_LEN_DEF-1:0] phv);
        return phv[QBMP_POS +: QBMP_W];
    endfunction

endpackage

// File: rtl/phv_queue_buffer_fifo.sv
// Single-queue first-word-fall-through PHV FIFO with slack-aware ready.
// Optional drop counter / high-water mark when PHV_QBUF_STATS_EN is defined.
module phv_fifo
    import phv_queue_buffer_pkg::*;
#(
    parameter int PHV_LEN     = PHV_LEN_DEF,
    parameter int DEPTH_BITS  = 4,
    parameter int AFULL_SLACK = 4
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_in_valid,
    output logic               phv_fifo_ready,
    output logic [PHV_LEN-1:0] phv_out,
    output logic               phv_out_valid,
    input  logic               phv_out_ready
`ifdef PHV_QBUF_STATS_EN
    ,
    output logic [31:0]        drop_cnt,
    output logic [DEPTH_BITS:0] hwm
`endif
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] SLACK_C = (DEPTH_BITS+1)'(AFULL_SLACK);

    if (AFULL_SLACK >= DEPTH) begin : g_bad_slack
        $error("phv_fifo: AFULL_SLACK must be smaller than the FIFO depth");
    end

    logic [PHV_LEN-1:0]    mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic [DEPTH_BITS:0]   count_nxt;
    logic                  live;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign full          = (count == DEPTH_C);
    assign phv_out_valid = (count != '0);
    assign pop           = phv_out_valid && phv_out_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still takes the push.
    assign push          = phv_in_valid && (!full || pop);
    assign drop          = phv_in_valid && full && !pop;

    // live keeps ready low throughout reset and for the release cycle itself.
    assign phv_fifo_ready = live && ((DEPTH_C - count) > SLACK_C);
    assign phv_out        = phv_out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= 1'b0;
        end else begin
            live  <= 1'b1;
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never reset; phv_out is masked to zero whenever the FIFO is empty.
    always_ff @(posedge axis_clk) begin
        if (push) mem[wr_ptr] <= phv_in;
    end

`ifdef PHV_QBUF_STATS_EN
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt <= '0;
            hwm      <= '0;
        end else begin
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
            if (count_nxt > hwm)          hwm      <= count_nxt;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: rtl/phv_queue_buffer.sv
// Four independent per-queue FWFT PHV FIFOs between the last match-action stage
// and the deparsers. Define PHV_QBUF_STATS_EN to add drop counters and high-water marks.
module phv_queue_buffer
    import phv_queue_buffer_pkg::*;
#(
    parameter int PHV_LEN     = PHV_LEN_DEF,
    parameter int DEPTH_BITS  = 4,
    parameter int AFULL_SLACK = 4
) (
    input  logic                axis_clk,
    input  logic                aresetn,
    input  logic [PHV_LEN-1:0]  phv_in_0,
    input  logic [PHV_LEN-1:0]  phv_in_1,
    input  logic [PHV_LEN-1:0]  phv_in_2,
    input  logic [PHV_LEN-1:0]  phv_in_3,
    input  logic                phv_in_valid_0,
    input  logic                phv_in_valid_1,
    input  logic                phv_in_valid_2,
    input  logic                phv_in_valid_3,
    output logic                phv_fifo_ready_0,
    output logic                phv_fifo_ready_1,
    output logic                phv_fifo_ready_2,
    output logic                phv_fifo_ready_3,
    output logic [PHV_LEN-1:0]  phv_out_0,
    output logic [PHV_LEN-1:0]  phv_out_1,
    output logic [PHV_LEN-1:0]  phv_out_2,
    output logic [PHV_LEN-1:0]  phv_out_3,
    output logic                phv_out_valid_0,
    output logic                phv_out_valid_1,
    output logic                phv_out_valid_2,
    output logic                phv_out_valid_3,
    input  logic                phv_out_ready_0,
    input  logic                phv_out_ready_1,
    input  logic                phv_out_ready_2,
    input  logic                phv_out_ready_3
`ifdef PHV_QBUF_STATS_EN
    ,
    output logic [31:0]         drop_cnt_0,
    output logic [31:0]         drop_cnt_1,
    output logic [31:0]         drop_cnt_2,
    output logic [31:0]         drop_cnt_3,
    output logic [DEPTH_BITS:0] hwm_0,
    output logic [DEPTH_BITS:0] hwm_1,
    output logic [DEPTH_BITS:0] hwm_2,
    output logic [DEPTH_BITS:0] hwm_3
`endif
);

    logic [PHV_LEN-1:0] in_d   [NUM_QUEUES];
    logic [PHV_LEN-1:0] out_d  [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] in_vld;
    logic [NUM_QUEUES-1:0] in_rdy;
    logic [NUM_QUEUES-1:0] out_vld;
    logic [NUM_QUEUES-1:0] out_rdy;

    assign in_d[0] = phv_in_0;
    assign in_d[1] = phv_in_1;
    assign in_d[2] = phv_in_2;
    assign in_d[3] = phv_in_3;
    assign in_vld  = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};
    assign out_rdy = {phv_out_ready_3, phv_out_ready_2, phv_out_ready_1, phv_out_ready_0};

    assign {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0} = in_rdy;
    assign {phv_out_valid_3, phv_out_valid_2, phv_out_valid_1, phv_out_valid_0}     = out_vld;
    assign phv_out_0 = out_d[0];
    assign phv_out_1 = out_d[1];
    assign phv_out_2 = out_d[2];
    assign phv_out_3 = out_d[3];

`ifdef PHV_QBUF_STATS_EN
    logic [31:0]         drop_d [NUM_QUEUES];
    logic [DEPTH_BITS:0] hwm_d  [NUM_QUEUES];

    assign drop_cnt_0 = drop_d[0];
    assign drop_cnt_1 = drop_d[1];
    assign drop_cnt_2 = drop_d[2];
    assign drop_cnt_3 = drop_d[3];
    assign hwm_0      = hwm_d[0];
    assign hwm_1      = hwm_d[1];
    assign hwm_2      = hwm_d[2];
    assign hwm_3      = hwm_d[3];
`endif

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
        phv_fifo #(
            .PHV_LEN     (PHV_LEN),
            .DEPTH_BITS  (DEPTH_BITS),
            .AFULL_SLACK (AFULL_SLACK)
        ) u_fifo (
            .axis_clk       (axis_clk),
            .aresetn        (aresetn),
            .phv_in         (in_d[q]),
            .phv_in_valid   (in_vld[q]),
            .phv_fifo_ready (in_rdy[q]),
            .phv_out        (out_d[q]),
            .phv_out_valid  (out_vld[q]),
            .phv_out_ready  (out_rdy[q])
`ifdef PHV_QBUF_STATS_EN
            ,
            .drop_cnt       (drop_d[q]),
            .hwm            (hwm_d[q])
`endif
        );
    end

endmodule

// File: tb/tb_phv_queue_buffer.sv
// Directed self-checking bench for phv_queue_buffer (DEPTH=16, SLACK=4);
// stats checks are active when PHV_QBUF_STATS_EN is defined.
module tb_phv_queue_buffer;

    localparam int W = 1024;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [W-1:0]  din  [4];
    logic [W-1:0]  dout [4];
    logic [3:0]    vin, ordy, vout, frdy;
`ifdef PHV_QBUF_STATS_EN
    logic [31:0]   dcnt [4];
    logic [4:0]    hwm  [4];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    phv_queue_buffer dut (
        .axis_clk(clk), .aresetn(aresetn),
        .phv_in_0(din[0]), .phv_in_1(din[1]), .phv_in_2(din[2]), .phv_in_3(din[3]),
        .phv_in_valid_0(vin[0]), .phv_in_valid_1(vin[1]),
        .phv_in_valid_2(vin[2]), .phv_in_valid_3(vin[3]),
        .phv_fifo_ready_0(frdy[0]), .phv_fifo_ready_1(frdy[1]),
        .phv_fifo_ready_2(frdy[2]), .phv_fifo_ready_3(frdy[3]),
        .phv_out_0(dout[0]), .phv_out_1(dout[1]), .phv_out_2(dout[2]), .phv_out_3(dout[3]),
        .phv_out_valid_0(vout[0]), .phv_out_valid_1(vout[1]),
        .phv_out_valid_2(vout[2]), .phv_out_valid_3(vout[3]),
        .phv_out_ready_0(ordy[0]), .phv_out_ready_1(ordy[1]),
        .phv_out_ready_2(ordy[2]), .phv_out_ready_3(ordy[3])
`ifdef PHV_QBUF_STATS_EN
        ,
        .drop_cnt_0(dcnt[0]), .drop_cnt_1(dcnt[1]), .drop_cnt_2(dcnt[2]), .drop_cnt_3(dcnt[3]),
        .hwm_0(hwm[0]), .hwm_1(hwm[1]), .hwm_2(hwm[2]), .hwm_3(hwm[3])
`endif
    );

    function automatic logic [W-1:0] mk(input int k);
        return {32{32'(k)}};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        vin     = '0;
        ordy    = '0;
        for (int q = 0; q < 4; q++) din[q] = '0;
        step();
        step();
        chk("rst_ready_low", W'(frdy), W'(4'b0000));
        chk("rst_valid_low", W'(vout), W'(4'b0000));
        aresetn = 1'b1;
        step();

        // 1. idle after release
        chk("idle_ready", W'(frdy), W'(4'b1111));
        chk("idle_valid", W'(vout), W'(4'b0000));
        for (int q = 0; q < 4; q++) chk($sformatf("idle_out%0d", q), dout[q], '0);
`ifdef PHV_QBUF_STATS_EN
        chk("idle_drop0", W'(dcnt[0]), '0);
        chk("idle_hwm0", W'(hwm[0]), '0);
`endif

        // 2. single PHV on q2, one-cycle latency, popped immediately
        din[2] = {128{8'hA5}};
        vin    = 4'b0100;
        ordy   = 4'b0100;
        step();
        vin = '0;
        chk("q2_valid_n1", W'(vout), W'(4'b0100));
        chk("q2_data_n1", dout[2], {128{8'hA5}});
        chk("q2_other_out0", dout[0], '0);
        step();
        chk("q2_valid_after_pop", W'(vout), W'(4'b0000));
        chk("q2_out_after_pop", dout[2], '0);
        ordy = '0;

        // 3. fill q0 past the slack threshold, then overflow
        for (int i = 0; i < 12; i++) begin
            din[0] = mk(i);
            vin[0] = 1'b1;
            step();
            if (i == 10) chk("q0_ready_at_11", W'(frdy[0]), W'(1'b1));
        end
        chk("q0_ready_at_12", W'(frdy[0]), W'(1'b0));
        for (int i = 12; i < 16; i++) begin
            din[0] = mk(i);
            step();
        end
        chk("q0_valid_full", W'(vout[0]), W'(1'b1));
        din[0] = mk(16);
        step();
        vin[0] = 1'b0;
        chk("q0_head_after_drop", dout[0], mk(0));
`ifdef PHV_QBUF_STATS_EN
        chk("q0_drop_cnt", W'(dcnt[0]), W'(32'd1));
        chk("q0_hwm", W'(hwm[0]), W'(5'd16));
`endif
        ordy[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("q0_drain_%0d", i), dout[0], mk(i));
            step();
        end
        chk("q0_empty_after_drain", W'(vout[0]), W'(1'b0));
        chk("q0_ready_after_drain", W'(frdy[0]), W'(1'b1));
        ordy[0] = 1'b0;

        // 4. q1 full, simultaneous push/pop for 32 beats
        for (int i = 0; i < 16; i++) begin
            din[1] = mk(100 + i);
            vin[1] = 1'b1;
            step();
        end
        ordy[1] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            din[1] = mk(116 + i);
            chk($sformatf("q1_pp_%0d", i), dout[1], mk(100 + i));
            step();
            if (i == 31) chk("q1_ready_still_low", W'(frdy[1]), W'(1'b0));
        end
        vin[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("q1_drain_%0d", i), dout[1], mk(132 + i));
            step();
        end
        chk("q1_empty", W'(vout[1]), W'(1'b0));
`ifdef PHV_QBUF_STATS_EN
        chk("q1_no_drop", W'(dcnt[1]), '0);
        chk("q1_hwm", W'(hwm[1]), W'(5'd16));
`endif
        ordy = '0;

        // 5. multicast to q0 and q3, held while not ready
        din[0] = mk(32'h5EED);
        din[3] = mk(32'h5EED);
        din[1] = mk(1);
        din[2] = mk(2);
        vin    = 4'b1001;
        step();
        vin = '0;
        chk("mc_valid", W'(vout), W'(4'b1001));
        chk("mc_out0", dout[0], mk(32'h5EED));
        chk("mc_out3", dout[3], mk(32'h5EED));
        chk("mc_out1_idle", dout[1], '0);
        chk("mc_out2_idle", dout[2], '0);
        step();
        chk("mc_hold0", dout[0], mk(32'h5EED));
        chk("mc_hold_valid", W'(vout), W'(4'b1001));
        ordy = 4'b1001;
        step();
        chk("mc_popped", W'(vout), W'(4'b0000));
        ordy = '0;

        // 6. reset mid-burst with 7 entries in q2
        for (int i = 0; i < 7; i++) begin
            din[2] = mk(200 + i);
            vin[2] = 1'b1;
            step();
        end
        vin[2] = 1'b0;
        chk("q2_seven_valid", W'(vout[2]), W'(1'b1));
        aresetn = 1'b0;
        #1;
        chk("async_rst_valid", W'(vout), W'(4'b0000));
        chk("async_rst_ready", W'(frdy), W'(4'b0000));
        chk("async_rst_out2", dout[2], '0);
        step();
        aresetn = 1'b1;
        step();
        chk("post_rst_ready", W'(frdy), W'(4'b1111));
        chk("post_rst_valid", W'(vout), W'(4'b0000));
`ifdef PHV_QBUF_STATS_EN
        chk("post_rst_drop0", W'(dcnt[0]), '0);
        chk("post_rst_hwm1", W'(hwm[1]), '0);
`endif
        din[2]  = mk(300);
        vin[2]  = 1'b1;
        ordy[2] = 1'b1;
        step();
        vin[2] = 1'b0;
        chk("post_rst_one_entry", dout[2], mk(300));
        step();
        chk("post_rst_count_zero", W'(vout[2]), W'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
